// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss timer: FSM states, mode encodings
// and the Mode B preset table.
package timer_pkg;

  localparam int unsigned MMSS_W = 16;

  localparam logic [MMSS_W-1:0] MMSS_ZERO      = 16'h0000;
  localparam logic [MMSS_W-1:0] MMSS_MAX       = 16'h5959;
  localparam logic [MMSS_W-1:0] MMSS_LAST_DOWN = 16'h0001;
  localparam logic [MMSS_W-1:0] MMSS_LAST_UP   = 16'h5958;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mode B start values, BCD mm:ss.
  function automatic logic [MMSS_W-1:0] preset_bcd(input logic [2:0] idx);
    case (idx)
      3'd0:    preset_bcd = 16'h0030;
      3'd1:    preset_bcd = 16'h0100;
      3'd2:    preset_bcd = 16'h0200;
      3'd3:    preset_bcd = 16'h0300;
      3'd4:    preset_bcd = 16'h0500;
      3'd5:    preset_bcd = 16'h1000;
      3'd6:    preset_bcd = 16'h1500;
      default: preset_bcd = 16'h3000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss up/down counter with synchronous load. The flags mark
// the value one step short of the limit, so the owner can stop on the same edge.
module bcd_mmss_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [15:0] load_val,
  input  logic       en,
  input  logic       down,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       at_zero,
  output logic       at_max
);

  logic [MMSS_W-1:0] count;
  logic [MMSS_W-1:0] stepped;
  logic [MMSS_W-1:0] nxt;
  logic [3:0]        m1, m0, s1, s0;

  assign {m1, m0, s1, s0} = count;

  // Single BCD step with carry/borrow; saturates at both ends.
  always_comb begin
    stepped = count;
    if (down) begin
      if (count != MMSS_ZERO) begin
        if (s0 != 4'd0) stepped[3:0] = s0 - 4'd1;
        else begin
          stepped[3:0] = 4'd9;
          if (s1 != 4'd0) stepped[7:4] = s1 - 4'd1;
          else begin
            stepped[7:4] = 4'd5;
            if (m0 != 4'd0) stepped[11:8] = m0 - 4'd1;
            else begin
              stepped[11:8]  = 4'd9;
              stepped[15:12] = m1 - 4'd1;
            end
          end
        end
      end
    end else begin
      if (count != MMSS_MAX) begin
        if (s0 != 4'd9) stepped[3:0] = s0 + 4'd1;
        else begin
          stepped[3:0] = 4'd0;
          if (s1 != 4'd5) stepped[7:4] = s1 + 4'd1;
          else begin
            stepped[7:4] = 4'd0;
            if (m0 != 4'd9) stepped[11:8] = m0 + 4'd1;
            else begin
              stepped[11:8]  = 4'd0;
              stepped[15:12] = m1 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    nxt = count;
    if (load)    nxt = load_val;
    else if (en) nxt = stepped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= MMSS_ZERO;
      at_zero <= 1'b0;
      at_max  <= 1'b0;
    end else begin
      count   <= nxt;
      at_zero <= (nxt == MMSS_LAST_DOWN);
      at_max  <= (nxt == MMSS_LAST_UP);
    end
  end

  assign min_bcd = count[15:8];
  assign sec_bcd = count[7:0];

endmodule

// File: rtl/timer_core.sv
// Two-mode mm:ss timer core: one-second prescaler, run/pause/done FSM and
// BCD counter. resetter is the upstream synchronous clear.
module timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resetter,
  input  logic       ModeSel,
  input  logic [2:0] TimeControl,
  input  logic       start_stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       tick
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic               wrap;
  logic               step;
  logic               hit;
  logic               cnt_load;
  logic [MMSS_W-1:0]  load_val;
  logic               at_zero;
  logic               at_max;

  assign wrap     = (presc == PRESC_LAST);
  assign step     = (state == ST_RUN) && wrap && !resetter;
  assign hit      = (ModeSel == MODE_B) ? at_zero : at_max;
  assign cnt_load = resetter || (state == ST_IDLE);
  assign load_val = (ModeSel == MODE_B) ? preset_bcd(TimeControl) : MMSS_ZERO;

  bcd_mmss_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .en       (step),
    .down     (ModeSel),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .at_zero  (at_zero),
    .at_max   (at_max)
  );

  // Run/pause/done FSM; a wrap always completes its step before any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (resetter) begin
      state   <= ST_IDLE;
      presc   <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          presc <= '0;
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            presc <= '0;
            tick  <= 1'b1;
          end else begin
            presc <= presc + PRESC_W'(1);
          end
          if (wrap && hit) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (start_stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core with TICK_DIV=4; expected values are hand-derived.
module tb_timer_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       resetter = 1'b0;
  logic       ModeSel = 1'b0;
  logic [2:0] TimeControl = 3'd0;
  logic       start_stop = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       tick;

  int checks = 0;
  int errors = 0;

  timer_core #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .resetter    (resetter),
    .ModeSel     (ModeSel),
    .TimeControl (TimeControl),
    .start_stop  (start_stop),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd),
    .running     (running),
    .done        (done),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    resetter = 1'b1;
    cyc(1);
    resetter = 1'b0;
  endtask

  function automatic logic [15:0] mmss();
    return {min_bcd, sec_bcd};
  endfunction

  initial begin
    int n;

    // 1: async reset with no clock edge, then load 00:30 preset
    #2 rst = 1'b1;
    #1;
    check("rst_count", 32'(mmss()), 32'h0000);
    check("rst_flags", {29'd0, running, done, tick}, 32'd0);
    cyc(1);
    rst = 1'b0;
    ModeSel = 1'b1;
    TimeControl = 3'd0;
    pulse_clr();
    check("preset0", 32'(mmss()), 32'h0030);

    // 2: Mode B countdown from 00:30
    pulse_ss();
    check("b_running", 32'(running), 32'd1);
    cyc(3);
    check("b_pre_tick", {15'd0, tick, mmss()}, {15'd0, 1'b0, 16'h0030});
    cyc(1);
    check("b_first_tick", {15'd0, tick, mmss()}, {15'd0, 1'b1, 16'h0029});
    cyc(116);
    check("b_end", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b011, 16'h0000});
    pulse_ss();
    cyc(5);
    check("b_done_hold", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b010, 16'h0000});

    // 3: Mode A with BCD carry into minutes
    ModeSel = 1'b0;
    pulse_clr();
    check("a_clear", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b000, 16'h0000});
    pulse_ss();
    cyc(236);
    check("a_0059", 32'(mmss()), 32'h0059);
    cyc(4);
    check("a_0100", {15'd0, tick, mmss()}, {15'd0, 1'b1, 16'h0100});
    cyc(4);
    check("a_0101", 32'(mmss()), 32'h0101);

    // 4: pause after two RUN edges, hold ten cycles, resume
    pulse_clr();
    pulse_ss();
    cyc(1);
    pulse_ss();
    check("p_paused", 32'(running), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("p_hold", {15'd0, tick, mmss()}, {15'd0, 1'b0, 16'h0000});
    end
    pulse_ss();
    check("p_resumed", 32'(running), 32'd1);
    cyc(1);
    check("p_no_tick_yet", {15'd0, tick, mmss()}, {15'd0, 1'b0, 16'h0000});
    cyc(1);
    check("p_tick", {15'd0, tick, mmss()}, {15'd0, 1'b1, 16'h0001});

    // 5: resetter beats start_stop in the same cycle
    ModeSel = 1'b1;
    TimeControl = 3'd7;
    pulse_clr();
    pulse_ss();
    cyc(5);
    check("r_running", {15'd0, running, mmss()}, {15'd0, 1'b1, 16'h2959});
    resetter = 1'b1;
    start_stop = 1'b1;
    cyc(1);
    resetter = 1'b0;
    start_stop = 1'b0;
    check("r_idle", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b000, 16'h3000});
    cyc(8);
    check("r_idle_hold", {15'd0, running, mmss()}, {15'd0, 1'b0, 16'h3000});

    // Mode A saturates at 59:59 after 3599 steps
    ModeSel = 1'b0;
    pulse_clr();
    pulse_ss();
    n = 0;
    while (!done && n < 15000) begin
      cyc(1);
      n++;
    end
    check("max_cycles", 32'(n), 32'd14396);
    check("max_end", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b011, 16'h5959});
    cyc(1);
    check("max_hold", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b010, 16'h5959});

    // 6: async reset mid-RUN between edges
    pulse_clr();
    pulse_ss();
    cyc(9);
    check("x_before", {15'd0, running, mmss()}, {15'd0, 1'b1, 16'h0002});
    #2 rst = 1'b1;
    #1;
    check("x_async", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b000, 16'h0000});
    cyc(1);
    rst = 1'b0;
    cyc(10);
    check("x_frozen", {13'd0, running, done, tick, mmss()}, {13'd0, 3'b000, 16'h0000});
    pulse_ss();
    cyc(4);
    check("x_restart", {14'd0, running, tick, mmss()}, {14'd0, 2'b11, 16'h0001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_core.md
# timer_core

Counting core of the two-mode timer, sitting directly downstream of the reset-generation stage and consuming its `resetter` pulse as a synchronous clear. Mode A (`ModeSel`=0) is a count-up stopwatch from 00:00. Mode B (`ModeSel`=1) counts down from a preset chosen by `TimeControl`. The block divides the system clock to a one-second enable, holds the mm:ss count in BCD, and runs a small run/pause/done state machine driven by a start/stop pulse.

## Interface
- `TICK_DIV`, 50_000_000 — clock cycles per count step (one second); must be ≥ 2. The bench uses 4.
- `clk` in 1 — system clock; all state updates on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `resetter` in 1 — synchronous clear from the upstream reset-generation stage; active-high, sampled on `clk`.
- `ModeSel` in 1 — 0 = Mode A (count up), 1 = Mode B (count down).
- `TimeControl` in 3 — Mode B preset index.
- `start_stop` in 1 — single-cycle pulse; toggles run/pause.
- `min_bcd` out 8 — minutes, two BCD digits.
- `sec_bcd` out 8 — seconds, two BCD digits.
- `running` out 1 — high in RUN.
- `done` out 1 — high in DONE.
- `tick` out 1 — one-cycle pulse, high in the cycle a new count value first appears.

## Operation
- Preset table, indexed by `TimeControl` 0..7: 00:30, 01:00, 02:00, 03:00, 05:00, 10:00, 15:00, 30:00.
- Load value: 00:00 in Mode A; `preset[TimeControl]` in Mode B.
- States:
  - IDLE: the count reloads from the load value every cycle and the prescaler is held at 0. `start_stop` → RUN.
  - RUN: the prescaler counts 0..TICK_DIV-1 and wraps. When the prescaler is at TICK_DIV-1, the count steps once. `start_stop` → PAUSE.
  - PAUSE: the count and prescaler hold their values. `start_stop` → RUN, and the prescaler resumes from its held value.
  - DONE: the count holds and `start_stop` is ignored. Only `resetter` or `rst` leaves DONE.
- Step rules:
  - Mode A increments the count. Seconds go 59→00 with a carry into minutes.
  - Mode A reaching 59:59 on a step → DONE (the count saturates at 59:59).
  - Mode B decrements the count. Seconds go 00→59 with a borrow from minutes.
  - Mode B reaching 00:00 on a step → DONE.
- Step direction follows the current `ModeSel`. `ModeSel` and `TimeControl` changes are cleared by the upstream `resetter`; the core does no edge detection of its own.
- `resetter` has priority over `start_stop` in the same cycle: → IDLE, count = load value, prescaler 0, `tick` 0.
- `rst` asynchronously forces IDLE, count 00:00, prescaler 0, and all outputs low, with no clock edge needed. This applies mid-RUN as well.
- Every BCD digit is always valid: seconds tens digit 0..5, minutes ≤ 59.

## Timing
- Reset values: `min_bcd`=8'h00, `sec_bcd`=8'h00, `running`=0, `done`=0, `tick`=0.
- All outputs are registered.
- `running` goes high the cycle after the `start_stop` sample in IDLE or PAUSE.
- First step: the new count and `tick` appear TICK_DIV cycles after the edge that sampled the starting `start_stop`.
- After that, steps occur every TICK_DIV cycles while in RUN.
- `done` rises, `running` falls, and the final count value (00:00 or 59:59) appears on the same edge, with `tick`=1.
- A pause of N cycles delays the next tick by exactly N cycles.
- `start_stop` arriving in the same cycle as the prescaler wrap: the step completes, then the state changes.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - the `MODE_A`/`MODE_B` constants;
  - the preset table as a function `preset_bcd(idx)` returning 16-bit BCD mm:ss.
- Sub-module `bcd_mmss_counter`: synchronous load, up/down enable, direction input, and `at_zero`/`at_max` flags.
- The prescaler and FSM live in `timer_core`.

## Test plan
All scenarios use TICK_DIV=4.
1. `rst`=1 → immediately 00:00, `running`=0, `done`=0. Release `rst`, `ModeSel`=1, `TimeControl`=0, pulse `resetter` → display 00:30.
2. Mode B, preset 00:30, pulse `start_stop`:
   - 4 cycles later: 00:29 with `tick`=1.
   - after 30 ticks (120 cycles): 00:00, `done`=1, `running`=0.
   - a further `start_stop` pulse changes nothing.
3. Mode A from 00:00, run 61 ticks → 01:01. The step after 00:59 shows 01:00 (BCD carry).
4. Mode A: start, `start_stop` again after 2 RUN cycles, wait 10 cycles, restart → count is unchanged during the pause, and the next tick lands 2 cycles after the restart.
5. In RUN, Mode B `TimeControl`=7, `resetter` and `start_stop` asserted in the same cycle → next cycle shows IDLE, 30:00, `running`=0.
6. `rst` asserted mid-RUN between clock edges → outputs go to 00:00 and 0 before the next edge. The count stays frozen until `start_stop` is pulsed.
